// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU requesters and the register file write port.
// The master drives the requests; the slave (the arbiter) drives the ready and write-port signals.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_data;
  logic              rf_reg_write;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_write;
  logic              wb_src;
  logic [15:0]       conflict_cnt;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready, rf_reg_write, rf_rd, rf_write, wb_src, conflict_cnt
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, rf_reg_write, rf_rd, rf_write, wb_src, conflict_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and LSU writebacks (LSU first,
// ALU forced after STARVE_MAX denials). Define WB_ARB_BYPASS_EN to add read forwarding.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  regfile_wb_arbiter_if.slave wb
`ifdef WB_ARB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] byp_rs1,
  input  logic [ADDR_W-1:0] byp_rs2,
  input  logic [DATA_W-1:0] rf_read1,
  input  logic [DATA_W-1:0] rf_read2,
  output logic [DATA_W-1:0] fwd_read1,
  output logic [DATA_W-1:0] fwd_read2
`endif
);

  typedef enum logic [0:0] {
    PRIO_LSU  = 1'b0,
    FORCE_ALU = 1'b1
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_r;
  logic [3:0]        starve_r;
  logic              rf_reg_write_r;
  logic [ADDR_W-1:0] rf_rd_r;
  logic [DATA_W-1:0] rf_write_r;
  logic              wb_src_r;
  logic [15:0]       conflict_cnt_r;

  logic              grant_alu_s;
  logic              grant_lsu_s;
  logic              accept_s;
  logic [ADDR_W-1:0] sel_rd_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [3:0]        starve_inc_s;

  // Grant decision: LSU wins normally, ALU wins in the one-cycle forced state.
  always_comb begin
    grant_alu_s = 1'b0;
    grant_lsu_s = 1'b0;
    if (reset) begin
      grant_alu_s = 1'b0;
      grant_lsu_s = 1'b0;
    end else begin
      case (state_r)
        PRIO_LSU: begin
          grant_lsu_s = wb.lsu_valid;
          grant_alu_s = wb.alu_valid & ~wb.lsu_valid;
        end
        FORCE_ALU: begin
          grant_alu_s = wb.alu_valid;
          grant_lsu_s = wb.lsu_valid & ~wb.alu_valid;
        end
        default: begin
          grant_alu_s = 1'b0;
          grant_lsu_s = 1'b0;
        end
      endcase
    end
  end

  // Winner's payload mux and starvation counter increment.
  always_comb begin
    accept_s     = grant_alu_s | grant_lsu_s;
    starve_inc_s = starve_r + 4'd1;
    if (grant_lsu_s) begin
      sel_rd_s   = wb.lsu_rd;
      sel_data_s = wb.lsu_data;
    end else begin
      sel_rd_s   = wb.alu_rd;
      sel_data_s = wb.alu_data;
    end
  end

  // FSM, starvation counter, registered write port and conflict statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= PRIO_LSU;
      starve_r       <= 4'd0;
      rf_reg_write_r <= 1'b0;
      rf_rd_r        <= {ADDR_W{1'b0}};
      rf_write_r     <= {DATA_W{1'b0}};
      wb_src_r       <= 1'b0;
      conflict_cnt_r <= 16'd0;
    end else begin
      // Writes to x0 are consumed but never reach the register file.
      rf_reg_write_r <= accept_s && (sel_rd_s != {ADDR_W{1'b0}});
      if (accept_s) begin
        rf_rd_r    <= sel_rd_s;
        rf_write_r <= sel_data_s;
        wb_src_r   <= grant_lsu_s;
      end
      if (wb.alu_valid && wb.lsu_valid && (conflict_cnt_r != 16'hFFFF)) begin
        conflict_cnt_r <= conflict_cnt_r + 16'd1;
      end
      case (state_r)
        PRIO_LSU: begin
          if (wb.alu_valid && !grant_alu_s) begin
            starve_r <= starve_inc_s;
            if (starve_inc_s == STARVE_LIM) begin
              state_r <= FORCE_ALU;
            end else begin
              state_r <= PRIO_LSU;
            end
          end else begin
            starve_r <= 4'd0;
            state_r  <= PRIO_LSU;
          end
        end
        FORCE_ALU: begin
          starve_r <= 4'd0;
          state_r  <= PRIO_LSU;
        end
        default: begin
          starve_r <= 4'd0;
          state_r  <= PRIO_LSU;
        end
      endcase
    end
  end

  assign wb.alu_ready    = grant_alu_s;
  assign wb.lsu_ready    = grant_lsu_s;
  assign wb.rf_reg_write = rf_reg_write_r;
  assign wb.rf_rd        = rf_rd_r;
  assign wb.rf_write     = rf_write_r;
  assign wb.wb_src       = wb_src_r;
  assign wb.conflict_cnt = conflict_cnt_r;

`ifdef WB_ARB_BYPASS_EN
  // Forward the in-flight write to readers of the same register this cycle.
  always_comb begin
    if (rf_reg_write_r && (rf_rd_r != {ADDR_W{1'b0}}) && (rf_rd_r == byp_rs1)) begin
      fwd_read1 = rf_write_r;
    end else begin
      fwd_read1 = rf_read1;
    end
    if (rf_reg_write_r && (rf_rd_r != {ADDR_W{1'b0}}) && (rf_rd_r == byp_rs2)) begin
      fwd_read2 = rf_write_r;
    end else begin
      fwd_read2 = rf_read2;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a per-cycle behavioural model and literal spot checks.
module tb_regfile_wb_arbiter;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [ADDR_W-1:0] byp_rs1 = '0, byp_rs2 = '0;
  logic [DATA_W-1:0] rf_read1 = '0, rf_read2 = '0;
  logic [DATA_W-1:0] fwd_read1, fwd_read2;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb        (bus.slave)
`ifdef WB_ARB_BYPASS_EN
    ,
    .byp_rs1   (byp_rs1),
    .byp_rs2   (byp_rs2),
    .rf_read1  (rf_read1),
    .rf_read2  (rf_read2),
    .fwd_read1 (fwd_read1),
    .fwd_read2 (fwd_read2)
`endif
  );

`ifndef WB_ARB_BYPASS_EN
  assign fwd_read1 = '0;
  assign fwd_read2 = '0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] adat,
                       input logic lv, input logic [ADDR_W-1:0] lrd, input logic [DATA_W-1:0] ldat);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = adat;
    bus.lsu_valid = lv;
    bus.lsu_rd    = lrd;
    bus.lsu_data  = ldat;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Model state: what the registered outputs must show, and how long ALU has been refused.
  logic              m_we = 1'b0;
  logic [ADDR_W-1:0] m_rd = '0;
  logic [DATA_W-1:0] m_data = '0;
  logic              m_src = 1'b0;
  logic              m_known = 1'b1;
  int                m_conf = 0;
  int                m_denied = 0;
  bit                m_force = 1'b0;

  // Per-cycle comparison against the model, then the model advances on the inputs the edge will see.
  initial begin : compare
    logic e_ag, e_lg;
    logic [ADDR_W-1:0] w_rd;
    logic [DATA_W-1:0] w_data;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (reset) begin
        e_ag = 1'b0; e_lg = 1'b0;
      end else if (m_force) begin
        e_ag = bus.alu_valid;
        e_lg = bus.lsu_valid && !bus.alu_valid;
      end else begin
        e_lg = bus.lsu_valid;
        e_ag = bus.alu_valid && !bus.lsu_valid;
      end
      check("alu_ready", 32'(bus.alu_ready), 32'(e_ag));
      check("lsu_ready", 32'(bus.lsu_ready), 32'(e_lg));
      check("rf_reg_write", 32'(bus.rf_reg_write), 32'(m_we));
      check("wb_src", 32'(bus.wb_src), 32'(m_src));
      check("conflict_cnt", 32'(bus.conflict_cnt), 32'(m_conf));
      if (m_known) begin
        check("rf_rd", 32'(bus.rf_rd), 32'(m_rd));
        check("rf_write", bus.rf_write, m_data);
      end
`ifdef WB_ARB_BYPASS_EN
      check("fwd_read1", fwd_read1,
            (m_we && m_rd != 0 && m_rd == byp_rs1) ? m_data : rf_read1);
      check("fwd_read2", fwd_read2,
            (m_we && m_rd != 0 && m_rd == byp_rs2) ? m_data : rf_read2);
`endif
      if (reset) begin
        m_we = 1'b0; m_rd = '0; m_data = '0; m_src = 1'b0; m_known = 1'b1;
        m_conf = 0; m_denied = 0; m_force = 1'b0;
      end else begin
        w_rd   = e_lg ? bus.lsu_rd : bus.alu_rd;
        w_data = e_lg ? bus.lsu_data : bus.alu_data;
        m_we = (e_ag || e_lg) && (w_rd != 0);
        if (e_ag || e_lg) begin
          m_rd = w_rd; m_data = w_data; m_src = e_lg; m_known = (w_rd != 0);
        end
        if (bus.alu_valid && bus.lsu_valid && m_conf < 65535) m_conf++;
        if (m_force) begin
          m_force = 1'b0; m_denied = 0;
        end else if (bus.alu_valid && !e_ag) begin
          m_denied++;
          if (m_denied >= STARVE_MAX) m_force = 1'b1;
        end else begin
          m_denied = 0;
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] pattern;
    reset = 1'b1;
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    next_cycle();
    @(negedge clk);
    check("reset_alu_ready", 32'(bus.alu_ready), 32'd0);
    check("reset_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    next_cycle();
    @(negedge clk);
    check("reset_rf_reg_write", 32'(bus.rf_reg_write), 32'd0);
    check("reset_conflict_cnt", 32'(bus.conflict_cnt), 32'd0);
    next_cycle();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    next_cycle();

    // Single ALU write.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("alu_single_ready", 32'(bus.alu_ready), 32'd1);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("alu_single_we", 32'(bus.rf_reg_write), 32'd1);
    check("alu_single_rd", 32'(bus.rf_rd), 32'd5);
    check("alu_single_data", bus.rf_write, 32'hDEADBEEF);
    check("alu_single_src", 32'(bus.wb_src), 32'd0);
    next_cycle();

    // Priority: LSU first, ALU once LSU drops.
    drive(1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 32'h11);
    @(negedge clk);
    check("prio_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    check("prio_alu_denied", 32'(bus.alu_ready), 32'd0);
    next_cycle();
    drive(1'b1, 5'd4, 32'h22, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("prio_alu_ready", 32'(bus.alu_ready), 32'd1);
    check("prio_lsu_src", 32'(bus.wb_src), 32'd1);
    check("prio_lsu_rd", 32'(bus.rf_rd), 32'd3);
    check("prio_lsu_data", bus.rf_write, 32'h11);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("prio_alu_rd", 32'(bus.rf_rd), 32'd4);
    check("prio_alu_src", 32'(bus.wb_src), 32'd0);
    next_cycle();
    next_cycle();

    // Starvation from a clean reset: ALU forced every fourth cycle.
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    pattern = 8'h00;
    drive(1'b1, 5'd20, 32'hA0A0A0A0, 1'b1, 5'd10, 32'h50505050);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pattern = {pattern[6:0], bus.alu_ready};
      next_cycle();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("starve_pattern", 32'(pattern), 32'h00000011);
    @(negedge clk);
    check("starve_conflict_cnt", 32'(bus.conflict_cnt), 32'd8);
    next_cycle();

    // Writes to x0 are consumed without a register-file write.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("x0_ready", 32'(bus.alu_ready), 32'd1);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("x0_no_write", 32'(bus.rf_reg_write), 32'd0);
    next_cycle();

    // Same destination from both: LSU commits first, ALU overwrites next.
    drive(1'b1, 5'd9, 32'hBBBB0002, 1'b1, 5'd9, 32'hAAAA0001);
    next_cycle();
    drive(1'b1, 5'd9, 32'hBBBB0002, 1'b0, 5'd0, 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    next_cycle();
    next_cycle();

    // ALU dropping valid clears the run of denials.
    drive(1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'h12);
    next_cycle();
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'h13);
    next_cycle();
    drive(1'b1, 5'd14, 32'h14, 1'b1, 5'd15, 32'h15);
    for (int i = 0; i < 4; i++) next_cycle();

    // Reset in the middle of traffic drops the pending requests.
    reset = 1'b1;
    @(negedge clk);
    check("midreset_no_ready", 32'(bus.alu_ready | bus.lsu_ready), 32'd0);
    next_cycle();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("midreset_no_write", 32'(bus.rf_reg_write), 32'd0);
    next_cycle();

`ifdef WB_ARB_BYPASS_EN
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    byp_rs1 = 5'd7;
    rf_read1 = 32'h0;
    @(negedge clk);
    check("byp_hit", fwd_read1, 32'h1234);
    byp_rs1 = 5'd8;
    rf_read1 = 32'h5555;
    #1;
    check("byp_miss", fwd_read1, 32'h5555);
    next_cycle();
`endif

    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
